data_mem_be: RTL and testbench

//  Byte-addressable data memory for the pipelined RISC-V core (MEM stage).
//  It supersedes the plain word RAM and adds the following:
//   - byte enables and B/H/W(/D) access sizes;
//   - load sign/zero extension;
//   - misalignment detection;
//   - a registered read-valid strobe.

---
 rtl/data_mem_be_if.sv | 36 +++
 rtl/data_mem_be.sv | 124 ++++++++++++
 tb/tb_data_mem_be.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_be_if.sv
// Bus interface for data_mem_be: MEM-stage request, store data and load response.
//   daddr        byte address (word index above the lane offset)
//   MemRead      load request this cycle
//   MemWrite     store request this cycle
//   size         00=B, 01=H, 10=W, 11=D
//   unsigned_ld  1: zero-extend load, 0: sign-extend
//   ddata_w      right-aligned store data
//   ddata_r      right-aligned, extended load result
//   rvalid       ddata_r holds the previous-cycle load result
//   misaligned   previous-cycle request was misaligned or illegal
interface data_mem_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH+OFF_W-1:0] daddr;
    logic                        MemRead;
    logic                        MemWrite;
    logic [1:0]                  size;
    logic                        unsigned_ld;
    logic [DATA_WIDTH-1:0]       ddata_w;
    logic [DATA_WIDTH-1:0]       ddata_r;
    logic                        rvalid;
    logic                        misaligned;

    modport master (
        output daddr, MemRead, MemWrite, size, unsigned_ld, ddata_w,
        input  ddata_r, rvalid, misaligned
    );

    modport slave (
        input  daddr, MemRead, MemWrite, size, unsigned_ld, ddata_w,
        output ddata_r, rvalid, misaligned
    );
endinterface

// File: rtl/data_mem_be.sv
// Byte-addressable data memory for the MEM stage of the pipelined core.
// Stores are byte-lane masked and land at the clock edge; loads are captured
// into a read register and returned extended one cycle later with rvalid.
// Misaligned or illegal requests do nothing except pulse misaligned for one cycle.
// Ports:
//   CLK      rising-edge clock
//   RESET_N  asynchronous active-low reset (does not clear the array)
//   bus      data_mem_be_if slave: request, store data, load response
module data_mem_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic         CLK,
    input  logic         RESET_N,
    data_mem_be_if.slave bus
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam bit          HAS_D = (DATA_WIDTH == 64);

    // 2-state storage: powers up as zero and is never touched by reset.
    bit [DATA_WIDTH-1:0] mem [DEPTH];

    logic [OFF_W-1:0]      offset;
    logic [ADDR_WIDTH-1:0] widx;
    logic [3:0]            nbytes;
    logic [OFF_W-1:0]      align_mask;
    logic                  legal;
    logic                  do_wr;
    logic                  do_rd;
    logic                  bad_req;
    logic [NB-1:0]         lane_en;
    logic [DATA_WIDTH-1:0] wdata_sh;

    assign offset = bus.daddr[OFF_W-1:0];
    assign widx   = bus.daddr[ADDR_WIDTH+OFF_W-1:OFF_W];

    always_comb begin
        case (bus.size)
            2'b00:   nbytes = 4'd1;
            2'b01:   nbytes = 4'd2;
            2'b10:   nbytes = 4'd4;
            default: nbytes = 4'd8;
        endcase
        align_mask = OFF_W'(nbytes - 4'd1);
        legal      = ((offset & align_mask) == '0);
        if (bus.size == 2'b11 && !HAS_D) begin
            legal = 1'b0;
        end
        do_wr   = bus.MemWrite & legal;
        do_rd   = bus.MemRead & legal;
        bad_req = (bus.MemRead | bus.MemWrite) & ~legal;
        for (int unsigned b = 0; b < NB; b++) begin
            lane_en[b] = (b >= 32'(offset)) && (b < 32'(offset) + 32'(nbytes));
        end
        wdata_sh = bus.ddata_w << {offset, 3'b000};
    end

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (lane_en[b]) begin
                    mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Read register: nonblocking read of mem gives read-before-write on a same-word store.
    logic [DATA_WIDTH-1:0] word_q;
    logic [OFF_W-1:0]      off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  rvalid_q;
    logic                  mis_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            word_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            rvalid_q <= do_rd;
            mis_q    <= bad_req;
            if (do_rd) begin
                word_q <= mem[widx];
                off_q  <= offset;
                size_q <= bus.size;
                uns_q  <= bus.unsigned_ld;
            end
        end
    end

    // Extension is combinational from the held read register, so ddata_r holds with it.
    logic [DATA_WIDTH-1:0] shifted;
    logic [6:0]            nbits;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] ext;

    always_comb begin
        shifted = word_q >> {off_q, 3'b000};
        nbits   = 7'd8 << size_q;
        if (32'(nbits) > DATA_WIDTH) begin
            nbits = 7'(DATA_WIDTH);
        end
        sign_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i == 32'(nbits) - 1) begin
                sign_bit = shifted[i] & ~uns_q;
            end
        end
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ext[i] = (i < 32'(nbits)) ? shifted[i] : sign_bit;
        end
    end

    assign bus.ddata_r    = ext;
    assign bus.rvalid     = rvalid_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_data_mem_be.sv
module tb_data_mem_be;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    data_mem_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();
    data_mem_be #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );

    data_mem_be_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) bus64 ();
    data_mem_be #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut64 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus64)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_mis;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // Reference model: flat byte array, little-endian.
    byte unsigned mem_m [4096];

    function automatic bit ref_legal(int unsigned a, int unsigned sz);
        if (sz == 3) return 1'b0;
        return (a % (1 << sz)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(int unsigned a, int unsigned sz, bit uns);
        logic [63:0] v = '0;
        int unsigned n = 1 << sz;
        for (int unsigned i = 0; i < n; i++) v = v | (64'(mem_m[a + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(int unsigned a, int unsigned sz, logic [31:0] d);
        for (int unsigned i = 0; i < (1 << sz); i++) mem_m[a + i] = d[8*i +: 8];
    endtask

    task automatic issue(bit rd, bit wr, int unsigned a, int unsigned sz, bit uns,
                         logic [31:0] wd);
        exp_t e;
        @(negedge CLK);
        bus.MemRead = rd;
        bus.MemWrite = wr;
        bus.daddr = 12'(a);
        bus.size = 2'(sz);
        bus.unsigned_ld = uns;
        bus.ddata_w = wd;
        if (rd || wr) begin
            if (!ref_legal(a, sz)) begin
                e = '{is_mis: 1'b1, data: 32'h0, cyc: cyc};
                q.push_back(e);
            end else begin
                if (rd) begin
                    e = '{is_mis: 1'b0, data: ref_load(a, sz, uns), cyc: cyc};
                    q.push_back(e);
                end
                if (wr) ref_store(a, sz, wd);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge CLK);
            bus.MemRead = 1'b0;
            bus.MemWrite = 1'b0;
        end
    endtask

    // Monitor: pops one expectation per presented response; checks hold value otherwise.
    logic [31:0] hold_exp = '0;
    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (!RESET_N) begin
            hold_exp = '0;
        end else if (bus.rvalid || bus.misaligned) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: rvalid=%0b misaligned=%0b, required none",
                         bus.rvalid, bus.misaligned);
            end else begin
                e = q.pop_front();
                if (bus.rvalid && bus.misaligned) begin
                    n_bad++;
                    $display("FAIL both_flags: rvalid=1 misaligned=1, required only one");
                end else if (e.cyc + 1 != cyc) begin
                    n_bad++;
                    $display("FAIL latency: response at cycle %0d, required %0d", cyc, e.cyc + 1);
                end else if (e.is_mis != bus.misaligned) begin
                    n_bad++;
                    $display("FAIL resp_kind: misaligned=%0b, required %0b",
                             bus.misaligned, e.is_mis);
                end else if (!e.is_mis && bus.ddata_r !== e.data) begin
                    n_bad++;
                    $display("FAIL load_data: got %h, required %h", bus.ddata_r, e.data);
                end
                if (!e.is_mis) hold_exp = e.data;
            end
        end else begin
            n_cmp++;
            if (bus.ddata_r !== hold_exp) begin
                n_bad++;
                $display("FAIL hold_data: got %h, required %h", bus.ddata_r, hold_exp);
            end
        end
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic d64(bit rd, bit wr, int unsigned a, int unsigned sz, bit uns,
                       logic [63:0] wd);
        @(negedge CLK);
        bus64.MemRead = rd;
        bus64.MemWrite = wr;
        bus64.daddr = 13'(a);
        bus64.size = 2'(sz);
        bus64.unsigned_ld = uns;
        bus64.ddata_w = wd;
    endtask

    task automatic check64(string name, bit rv, bit mis, logic [63:0] d);
        @(posedge CLK);
        #1;
        check({name, "_rvalid"}, 64'(bus64.rvalid), 64'(rv));
        check({name, "_mis"}, 64'(bus64.misaligned), 64'(mis));
        if (rv) check({name, "_data"}, bus64.ddata_r, d);
    endtask

    initial begin
        int unsigned a, sz;
        bus.MemRead = 0; bus.MemWrite = 0; bus.daddr = '0; bus.size = '0;
        bus.unsigned_ld = 0; bus.ddata_w = '0;
        bus64.MemRead = 0; bus64.MemWrite = 0; bus64.daddr = '0; bus64.size = '0;
        bus64.unsigned_ld = 0; bus64.ddata_w = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("reset_rvalid", 64'(bus.rvalid), 64'd0);
        check("reset_mis", 64'(bus.misaligned), 64'd0);
        check("reset_ddata_r", 64'(bus.ddata_r), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Partial store over a word.
        issue(0, 1, 'h20, 2, 0, 32'h11223344);
        issue(0, 1, 'h21, 0, 0, 32'h000000AA);
        issue(1, 0, 'h20, 2, 0, 32'h0);
        // Extension cases.
        issue(0, 1, 'h40, 2, 0, 32'h80FF7F01);
        issue(1, 0, 'h42, 0, 0, 32'h0);
        issue(1, 0, 'h42, 0, 1, 32'h0);
        issue(1, 0, 'h42, 1, 0, 32'h0);
        issue(1, 0, 'h40, 1, 1, 32'h0);
        // Misaligned / illegal, then confirm nothing was written.
        issue(0, 1, 'h23, 1, 0, 32'h0000BEEF);
        issue(1, 0, 'h22, 2, 0, 32'h0);
        issue(1, 0, 'h20, 3, 0, 32'h0);
        issue(0, 1, 'h20, 3, 0, 32'hFFFFFFFF);
        issue(1, 0, 'h20, 2, 0, 32'h0);
        // Same-cycle load and store to one word: old data, then new.
        issue(1, 1, 'h30, 2, 0, 32'hDEADBEEF);
        issue(1, 0, 'h30, 2, 0, 32'h0);
        idle(2);

        // Reset while a load is in flight.
        @(negedge CLK);
        bus.MemRead = 1'b1;
        bus.daddr = 12'h010;
        bus.size = 2'b10;
        #2 RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_load_rvalid", 64'(bus.rvalid), 64'd0);
        check("rst_load_ddata_r", 64'(bus.ddata_r), 64'd0);
        @(negedge CLK);
        bus.MemRead = 1'b0;
        RESET_N = 1'b1;
        issue(1, 0, 'h20, 2, 0, 32'h0);
        issue(1, 0, 'h30, 2, 0, 32'h0);
        issue(1, 0, 'h40, 2, 0, 32'h0);
        idle(2);

        // Randomised mix, addresses clustered to force collisions.
        for (int i = 0; i < 600; i++) begin
            sz = $urandom_range(0, 3);
            a = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 127);
            if ($urandom_range(0, 9) < 8) a = a & ~((1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
                  1'($urandom_range(0, 1)), $urandom);
        end
        idle(4);
        check("queue_drained", 64'(q.size()), 64'd0);

        // 64-bit instance.
        d64(0, 1, 'h8, 3, 0, 64'h0123456789ABCDEF);
        check64("sd", 0, 0, 64'h0);
        d64(1, 0, 'hC, 2, 0, 64'h0);
        check64("lw_c", 1, 0, 64'h0000000001234567);
        d64(1, 0, 'h8, 2, 0, 64'h0);
        check64("lw_8", 1, 0, 64'hFFFFFFFF89ABCDEF);
        d64(1, 0, 'h8, 2, 1, 64'h0);
        check64("lwu_8", 1, 0, 64'h0000000089ABCDEF);
        d64(0, 1, 'hC, 3, 0, 64'hFFFFFFFFFFFFFFFF);
        check64("sd_mis", 0, 1, 64'h0);
        d64(1, 0, 'h8, 3, 0, 64'h0);
        check64("ld_8", 1, 0, 64'h0123456789ABCDEF);
        d64(0, 1, 'hF, 0, 0, 64'h77);
        check64("sb_f", 0, 0, 64'h0);
        d64(1, 0, 'hE, 1, 1, 64'h0);
        check64("lhu_e", 1, 0, 64'h0000000000007723);
        d64(0, 0, 'h0, 0, 0, 64'h0);
        check64("idle64", 0, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
